// File: rtl/csr_commit_serializer.sv
// csr_commit_serializer
// Buffers per-commit bundles of CSR write records in a circular FIFO and
// replays them one record per handshake, tagged with the commit sequence
// number and a flag marking the last record of each bundle. Lets a commit
// that writes several CSRs at once (trap entry and similar) feed a
// comparator that only accepts one record per cycle.
// Record ids are carried as raw csr_id_e encodings of KEY_W bits and are
// passed through unchecked.

module csr_commit_serializer #(
    parameter int KEY_W          = 12,
    parameter int DATA_W         = 64,
    parameter int SEQ_W          = 32,
    parameter int MAX_PER_COMMIT = 4,
    parameter int DEPTH          = 16,
    localparam int CNT_W         = $clog2(MAX_PER_COMMIT + 1),
    localparam int PTR_W         = $clog2(DEPTH),
    localparam int OCC_W         = $clog2(DEPTH) + 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_i,
    input  logic                                    commit_valid_i,
    output logic                                    commit_ready_o,
    input  logic [CNT_W-1:0]                        commit_cnt_i,
    input  logic [SEQ_W-1:0]                        commit_seq_i,
    input  logic [MAX_PER_COMMIT-1:0][KEY_W-1:0]    commit_id_i,
    input  logic [MAX_PER_COMMIT-1:0][DATA_W-1:0]   commit_data_i,
    output logic                                    rec_valid_o,
    input  logic                                    rec_ready_i,
    output logic [KEY_W-1:0]                        rec_id_o,
    output logic [DATA_W-1:0]                       rec_data_o,
    output logic [SEQ_W-1:0]                        rec_seq_o,
    output logic                                    rec_last_o,
    output logic [OCC_W-1:0]                        occupancy_o,
    output logic                                    err_cnt_ovf_o
);

    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PER_COMMIT);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] MAX_OCC   = OCC_W'(MAX_PER_COMMIT);

    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              errOvf_q, errOvf_d;

    logic [KEY_W-1:0]  memId_q   [DEPTH];
    logic [DATA_W-1:0] memData_q [DEPTH];
    logic [SEQ_W-1:0]  memSeq_q  [DEPTH];
    logic              memLast_q [DEPTH];

    logic              overCnt;
    logic [CNT_W-1:0]  pushCnt;
    logic              pushEff;
    logic              popEff;
    logic              wrEn   [MAX_PER_COMMIT];
    logic [PTR_W-1:0]  wrIdx  [MAX_PER_COMMIT];
    logic              wrLast [MAX_PER_COMMIT];

    // Handshake qualification: ready looks only at registered occupancy, so a
    // full bundle always fits; a flush discards any push or pop in its cycle.
    always_comb begin
        commit_ready_o = (DEPTH_OCC - occ_q) >= MAX_OCC;
        overCnt        = commit_cnt_i > MAX_CNT;
        pushCnt        = overCnt ? MAX_CNT : commit_cnt_i;
        pushEff        = commit_valid_i & commit_ready_o & ~flush_i;
        popEff         = (occ_q != '0) & rec_ready_i & ~flush_i;
    end

    // Per-slot write enables and target addresses; slot k lands k entries past
    // the write pointer, and only the final valid slot carries the last flag.
    always_comb begin
        for (int k = 0; k < MAX_PER_COMMIT; k++) begin
            wrEn[k]   = pushEff && (CNT_W'(k) < pushCnt);
            wrIdx[k]  = wrPtr_q + PTR_W'(k);
            wrLast[k] = (CNT_W'(k + 1) == pushCnt);
        end
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        occ_d    = occ_q;
        errOvf_d = errOvf_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            occ_d   = '0;
        end else begin
            if (pushEff) begin
                wrPtr_d = wrPtr_q + PTR_W'(pushCnt);
                if (overCnt) begin
                    errOvf_d = 1'b1;
                end
            end
            if (popEff) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            occ_d = occ_q + (pushEff ? OCC_W'(pushCnt) : '0) - (popEff ? OCC_W'(1) : '0);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            occ_q    <= '0;
            errOvf_q <= 1'b0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            occ_q    <= occ_d;
            errOvf_q <= errOvf_d;
        end
    end

    // Record storage; contents are only meaningful below occupancy, so it has no reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < MAX_PER_COMMIT; k++) begin
            if (wrEn[k]) begin
                memId_q[wrIdx[k]]   <= commit_id_i[k];
                memData_q[wrIdx[k]] <= commit_data_i[k];
                memSeq_q[wrIdx[k]]  <= commit_seq_i;
                memLast_q[wrIdx[k]] <= wrLast[k];
            end
        end
    end

    // Show-ahead output straight from the head entry.
    always_comb begin
        rec_valid_o   = occ_q != '0;
        rec_id_o      = memId_q[rdPtr_q];
        rec_data_o    = memData_q[rdPtr_q];
        rec_seq_o     = memSeq_q[rdPtr_q];
        rec_last_o    = memLast_q[rdPtr_q];
        occupancy_o   = occ_q;
        err_cnt_ovf_o = errOvf_q;
    end

endmodule

// File: tb/tb_csr_commit_serializer.sv
// tb_csr_commit_serializer
// Directed bench with a scoreboard: every accepted bundle pushes its expected
// records into a queue, and each record the DUT hands over is popped and
// compared in order.

module tb_csr_commit_serializer;

    localparam int KEY_W  = 12;
    localparam int DATA_W = 64;
    localparam int SEQ_W  = 32;
    localparam int MAXC   = 4;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic [KEY_W-1:0]  id;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
        logic              last;
    } rec_t;

    logic                         clk_i = 1'b0;
    logic                         rst_i;
    logic                         flush_i;
    logic                         commit_valid_i;
    logic                         commit_ready_o;
    logic [2:0]                   commit_cnt_i;
    logic [SEQ_W-1:0]             commit_seq_i;
    logic [MAXC-1:0][KEY_W-1:0]   commit_id_i;
    logic [MAXC-1:0][DATA_W-1:0]  commit_data_i;
    logic                         rec_valid_o;
    logic                         rec_ready_i;
    logic [KEY_W-1:0]             rec_id_o;
    logic [DATA_W-1:0]            rec_data_o;
    logic [SEQ_W-1:0]             rec_seq_o;
    logic                         rec_last_o;
    logic [4:0]                   occupancy_o;
    logic                         err_cnt_ovf_o;

    int   total = 0;
    int   bad   = 0;
    rec_t sb[$];

    csr_commit_serializer #(
        .KEY_W(KEY_W), .DATA_W(DATA_W), .SEQ_W(SEQ_W),
        .MAX_PER_COMMIT(MAXC), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
        .commit_cnt_i(commit_cnt_i), .commit_seq_i(commit_seq_i),
        .commit_id_i(commit_id_i), .commit_data_i(commit_data_i),
        .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_id_o(rec_id_o), .rec_data_o(rec_data_o), .rec_seq_o(rec_seq_o),
        .rec_last_o(rec_last_o), .occupancy_o(occupancy_o),
        .err_cnt_ovf_o(err_cnt_ovf_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // One comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; a record consumed at this edge is checked against the scoreboard first.
    task automatic tick();
        rec_t exp;
        if (rec_valid_o && rec_ready_i && !flush_i && !rst_i) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rec", {rec_id_o, rec_data_o, rec_seq_o, rec_last_o}, '0);
            end else begin
                exp = sb.pop_front();
                checkOutput("rec", {rec_id_o, rec_data_o, rec_seq_o, rec_last_o}, exp);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    // Drive one bundle for one cycle and record what should come out of it.
    task automatic applyStimulus(input int cnt, input logic [SEQ_W-1:0] seq,
                                 input logic [MAXC-1:0][KEY_W-1:0] ids,
                                 input logic [MAXC-1:0][DATA_W-1:0] dat);
        int n;
        rec_t r;
        n = (cnt > MAXC) ? MAXC : cnt;
        for (int k = 0; k < n; k++) begin
            r.id   = ids[k];
            r.data = dat[k];
            r.seq  = seq;
            r.last = (k == n - 1);
            sb.push_back(r);
        end
        commit_valid_i = 1'b1;
        commit_cnt_i   = 3'(cnt);
        commit_seq_i   = seq;
        commit_id_i    = ids;
        commit_data_i  = dat;
        tick();
        commit_valid_i = 1'b0;
        commit_cnt_i   = '0;
    endtask

    // Consume until the scoreboard is empty, within a cycle budget.
    task automatic drain(input int budget);
        rec_ready_i = 1'b1;
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        checkOutput("drain_sb_empty", 128'(sb.size()), 128'd0);
        checkOutput("drain_occ", 128'(occupancy_o), 128'd0);
        checkOutput("drain_valid", 128'(rec_valid_o), 128'd0);
    endtask

    logic [MAXC-1:0][KEY_W-1:0]  ids;
    logic [MAXC-1:0][DATA_W-1:0] dat;

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; commit_valid_i = 1'b0; commit_cnt_i = '0;
        commit_seq_i = '0; commit_id_i = '0; commit_data_i = '0; rec_ready_i = 1'b0;

        // Reset state and idle after release
        #1;
        checkOutput("rst_valid", 128'(rec_valid_o), 128'd0);
        checkOutput("rst_occ", 128'(occupancy_o), 128'd0);
        checkOutput("rst_ready", 128'(commit_ready_o), 128'd1);
        checkOutput("rst_err", 128'(err_cnt_ovf_o), 128'd0);
        tick(); tick();
        rst_i = 1'b0;
        tick(); tick(); tick();
        checkOutput("idle_valid", 128'(rec_valid_o), 128'd0);
        checkOutput("idle_occ", 128'(occupancy_o), 128'd0);

        // Trap-style bundle drained back-to-back
        rec_ready_i = 1'b1;
        ids = {12'h343, 12'h342, 12'h341, 12'h300};
        dat = {64'd4, 64'd3, 64'd2, 64'd1};
        checkOutput("pre_push_valid", 128'(rec_valid_o), 128'd0);
        applyStimulus(4, 32'd7, ids, dat);
        checkOutput("push_next_valid", 128'(rec_valid_o), 128'd1);
        tick(); tick(); tick(); tick();
        checkOutput("four_cycle_sb", 128'(sb.size()), 128'd0);
        checkOutput("four_cycle_occ", 128'(occupancy_o), 128'd0);

        // Fill to full with the consumer stalled
        rec_ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < MAXC; k++) begin
                ids[k] = 12'(12'h100 + b * 4 + k);
                dat[k] = {$urandom, $urandom};
            end
            applyStimulus(4, 32'(10 + b), ids, dat);
        end
        checkOutput("occ12", 128'(occupancy_o), 128'd12);
        checkOutput("ready_at12", 128'(commit_ready_o), 128'd1);
        for (int k = 0; k < MAXC; k++) begin
            ids[k] = 12'(12'h200 + k);
            dat[k] = {$urandom, $urandom};
        end
        applyStimulus(4, 32'd13, ids, dat);
        checkOutput("occ16", 128'(occupancy_o), 128'd16);
        checkOutput("ready_at16", 128'(commit_ready_o), 128'd0);
        rec_ready_i = 1'b1;
        tick();
        rec_ready_i = 1'b0;
        checkOutput("occ15", 128'(occupancy_o), 128'd15);
        checkOutput("ready_at15", 128'(commit_ready_o), 128'd0);
        drain(40);

        // Wrap: write pointer is at 4 now, so ten more records bring it to 14
        rec_ready_i = 1'b0;
        for (int k = 0; k < MAXC; k++) begin
            ids[k] = 12'(12'h400 + k);
            dat[k] = 64'(k + 100);
        end
        applyStimulus(4, 32'd20, ids, dat);
        applyStimulus(4, 32'd21, ids, dat);
        applyStimulus(2, 32'd22, ids, dat);
        checkOutput("wrap_preload_occ", 128'(occupancy_o), 128'd10);
        ids = {12'hb02, 12'hb00, 12'hc02, 12'hc00};
        dat = {64'hdead_0003, 64'hdead_0002, 64'hdead_0001, 64'hdead_0000};
        applyStimulus(4, 32'd23, ids, dat);
        checkOutput("wrap_occ", 128'(occupancy_o), 128'd14);
        drain(40);

        // Push and pop in the same cycle, empty bundle, oversize bundle
        rec_ready_i = 1'b0;
        ids = {12'h004, 12'h003, 12'h002, 12'h001};
        dat = {64'd44, 64'd33, 64'd22, 64'd11};
        applyStimulus(1, 32'd30, ids, dat);
        checkOutput("occ1", 128'(occupancy_o), 128'd1);
        rec_ready_i = 1'b1;
        applyStimulus(2, 32'd31, ids, dat);
        rec_ready_i = 1'b0;
        checkOutput("push_pop_occ", 128'(occupancy_o), 128'd2);
        applyStimulus(0, 32'd32, ids, dat);
        checkOutput("cnt0_occ", 128'(occupancy_o), 128'd2);
        checkOutput("cnt0_ready", 128'(commit_ready_o), 128'd1);
        checkOutput("cnt0_err", 128'(err_cnt_ovf_o), 128'd0);
        applyStimulus(5, 32'd33, ids, dat);
        checkOutput("cnt5_occ", 128'(occupancy_o), 128'd6);
        checkOutput("cnt5_err", 128'(err_cnt_ovf_o), 128'd1);

        // Asynchronous reset in the middle of a drain
        rec_ready_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_valid", 128'(rec_valid_o), 128'd0);
        checkOutput("async_rst_occ", 128'(occupancy_o), 128'd0);
        checkOutput("async_rst_err", 128'(err_cnt_ovf_o), 128'd0);
        sb.delete();
        rec_ready_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();

        // Flush beats a simultaneous push and keeps the error flag
        applyStimulus(6, 32'd40, ids, dat);
        checkOutput("pre_flush_occ", 128'(occupancy_o), 128'd4);
        checkOutput("pre_flush_err", 128'(err_cnt_ovf_o), 128'd1);
        flush_i = 1'b1;
        rec_ready_i = 1'b1;
        applyStimulus(2, 32'd41, ids, dat);
        flush_i = 1'b0;
        sb.delete();
        checkOutput("flush_occ", 128'(occupancy_o), 128'd0);
        checkOutput("flush_valid", 128'(rec_valid_o), 128'd0);
        checkOutput("flush_err_kept", 128'(err_cnt_ovf_o), 128'd1);
        tick();
        checkOutput("post_flush_idle", 128'(rec_valid_o), 128'd0);
        applyStimulus(1, 32'd42, ids, dat);
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
